// File: rtl/hx8k_demo.sv
// -----------------------------------------------------------------------------
// hx8k_demo
//   Streams a zero-terminated byte string from SPI flash out of a UART.
//   Sequence: wake the flash (0xAB), pause with chip select high, issue a read
//   (0x03 + 24-bit address), then fetch and transmit one byte at a time. It
//   stops at the first 0x00 byte or after MAX_BYTES bytes. The last byte sent
//   is shown on the LEDs.
//
//   Optional feature (macro HX8K_DEMO_RX_EN): a UART receiver. A received
//   frame with a valid stop bit updates the LEDs. Once the stream is DONE, the
//   received byte is also echoed on ser_tx.
//
// Parameters
//   BAUD_DIV    clock cycles per UART bit
//   FLASH_ADDR  flash start address of the byte stream
//   MAX_BYTES   maximum bytes streamed per run
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   leds[7:0]    last streamed or received byte
//   ser_rx       UART receive (idle high, asynchronous)
//   ser_tx       UART transmit (idle high)
//   flash_csb    SPI chip select, active low
//   flash_clk    SPI clock, mode 0, clk/2 while selected
//   flash_io0    SPI MOSI
//   flash_io1    SPI MISO
//   flash_io2/3  held high (WP#/HOLD# inactive)
//   dbg_state_o  current sequencer state (debug)
// -----------------------------------------------------------------------------
module hx8k_demo #(
  parameter int          BAUD_DIV   = 106,
  parameter logic [23:0] FLASH_ADDR = 24'h100000,
  parameter int          MAX_BYTES  = 256
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] leds,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       flash_csb,
  output logic       flash_clk,
  output logic       flash_io0,
  input  logic       flash_io1,
  output logic       flash_io2,
  output logic       flash_io3,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_WAKE = 3'd0,
    S_GAP  = 3'd1,
    S_CMD  = 3'd2,
    S_READ = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5
  } state_e;

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [8:0]  LAST_CNT  = 9'(MAX_BYTES - 1);

  // Sequencer and SPI shift engine state
  state_e      state_q, state_d;
  logic        csb_q, csb_d;
  logic        sck_q, sck_d;
  logic        io0_q, io0_d;
  logic        run_q, run_d;
  logic [5:0]  bits_q, bits_d;   // rising SCK edges still to come
  logic [31:0] sh_q, sh_d;       // outgoing bits, MSB first
  logic [7:0]  miso_q, miso_d;
  logic [2:0]  gap_q, gap_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        sent_q, sent_d;
  logic [7:0]  leds_q, leds_d;

  // Transmitter request: tx_start is taken only while tx_busy_q is low.
  // tx_busy_q rises on the next edge and falls exactly at the end of the stop bit.
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_busy_q, tx_q;
  logic [8:0]  tx_sh_q;
  logic [3:0]  tx_bit_q;
  logic [15:0] tx_div_q;

  logic        spi_go, spi_done;
  logic [31:0] spi_word;
  logic [5:0]  spi_len;

  logic        rx_valid;
  logic [7:0]  rx_byte;

`ifdef HX8K_DEMO_RX_EN
  localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);

  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_busy_q, rx_valid_q;
  logic [15:0] rx_div_q;
  logic [3:0]  rx_bit_q;
  logic [7:0]  rx_sh_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_div_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
    end else begin
      rx_s1_q    <= ser_rx;
      rx_s2_q    <= rx_s1_q;
      rx_prev_q  <= rx_s2_q;
      rx_valid_q <= 1'b0;
      if (!rx_busy_q) begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_busy_q <= 1'b1;
          rx_div_q  <= HALF_LAST;
          rx_bit_q  <= '0;
        end
      end else if (rx_div_q != 16'd0) begin
        rx_div_q <= rx_div_q - 16'd1;
      end else begin
        rx_div_q <= BAUD_LAST;
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0) begin
          // Line back high at mid start bit: a glitch, not a frame.
          if (rx_s2_q) rx_busy_q <= 1'b0;
        end else if (rx_bit_q == 4'd9) begin
          rx_busy_q  <= 1'b0;
          rx_valid_q <= rx_s2_q;
        end else begin
          rx_sh_q <= {rx_s2_q, rx_sh_q[7:1]};
        end
      end
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_sh_q;
`else
  logic unused_rx;
  assign unused_rx = ser_rx;
  assign rx_valid  = 1'b0;
  assign rx_byte   = 8'h00;
`endif

  always_comb begin
    state_d  = state_q;
    csb_d    = csb_q;
    sck_d    = sck_q;
    io0_d    = io0_q;
    run_d    = run_q;
    bits_d   = bits_q;
    sh_d     = sh_q;
    miso_d   = miso_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    sent_d   = sent_q;
    leds_d   = leds_q;
    tx_start = 1'b0;
    tx_byte  = miso_q;
    spi_go   = 1'b0;
    spi_word = 32'h0;
    spi_len  = 6'd8;
    spi_done = 1'b0;

    // Shift engine: sample MISO as SCK rises, move MOSI as SCK falls.
    // Completion is flagged on the falling edge after the last bit.
    if (run_q) begin
      if (!sck_q) begin
        sck_d  = 1'b1;
        miso_d = {miso_q[6:0], flash_io1};
        bits_d = bits_q - 6'd1;
      end else begin
        sck_d = 1'b0;
        if (bits_q == 6'd0) begin
          run_d    = 1'b0;
          io0_d    = 1'b0;
          spi_done = 1'b1;
        end else begin
          io0_d = sh_q[31];
          sh_d  = {sh_q[30:0], 1'b0};
        end
      end
    end

    case (state_q)
      S_WAKE: begin
        if (spi_done) begin
          csb_d   = 1'b1;
          gap_d   = 3'd0;
          state_d = S_GAP;
        end else if (!run_q) begin
          spi_go   = 1'b1;
          spi_word = {8'hAB, 24'h0};
          spi_len  = 6'd8;
        end
      end
      S_GAP: begin
        // Seven GAP cycles plus the first CMD cycle give eight cycles with csb high.
        if (gap_q == 3'd6) state_d = S_CMD;
        else               gap_d   = gap_q + 3'd1;
      end
      S_CMD: begin
        if (spi_done) begin
          state_d = S_READ;
        end else if (!run_q) begin
          spi_go   = 1'b1;
          spi_word = {8'h03, FLASH_ADDR};
          spi_len  = 6'd32;
        end
      end
      S_READ: begin
        if (spi_done) begin
          if (miso_q == 8'h00) begin
            csb_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            sent_d  = 1'b0;
            state_d = S_SEND;
          end
        end else if (!run_q) begin
          spi_go   = 1'b1;
          spi_word = 32'h0;
          spi_len  = 6'd8;
        end
      end
      S_SEND: begin
        // csb stays low with SCK parked so the read continues afterwards.
        if (!sent_q) begin
          tx_start = 1'b1;
          leds_d   = miso_q;
          sent_d   = 1'b1;
        end else if (!tx_busy_q) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_q == LAST_CNT) begin
            csb_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_READ;
          end
        end
      end
      S_DONE: begin
        csb_d = 1'b1;
        if (rx_valid && !tx_busy_q) begin
          tx_start = 1'b1;
          tx_byte  = rx_byte;
        end
      end
      default: state_d = S_WAKE;
    endcase

    // First MOSI bit is presented as csb falls, ahead of the first rising SCK.
    if (spi_go) begin
      csb_d  = 1'b0;
      run_d  = 1'b1;
      bits_d = spi_len;
      io0_d  = spi_word[31];
      sh_d   = {spi_word[30:0], 1'b0};
    end

    if (rx_valid) leds_d = rx_byte;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_WAKE;
      csb_q   <= 1'b1;
      sck_q   <= 1'b0;
      io0_q   <= 1'b0;
      run_q   <= 1'b0;
      bits_q  <= '0;
      sh_q    <= '0;
      miso_q  <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      sent_q  <= 1'b0;
      leds_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      csb_q   <= csb_d;
      sck_q   <= sck_d;
      io0_q   <= io0_d;
      run_q   <= run_d;
      bits_q  <= bits_d;
      sh_q    <= sh_d;
      miso_q  <= miso_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
      leds_q  <= leds_d;
    end
  end

  // UART transmitter: start bit, 8 data bits LSB first, stop bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
      tx_sh_q   <= '0;
      tx_bit_q  <= '0;
      tx_div_q  <= '0;
    end else if (!tx_busy_q) begin
      if (tx_start) begin
        tx_busy_q <= 1'b1;
        tx_q      <= 1'b0;
        tx_sh_q   <= {1'b1, tx_byte};
        tx_bit_q  <= '0;
        tx_div_q  <= BAUD_LAST;
      end
    end else if (tx_div_q != 16'd0) begin
      tx_div_q <= tx_div_q - 16'd1;
    end else if (tx_bit_q == 4'd9) begin
      tx_busy_q <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      tx_q     <= tx_sh_q[0];
      tx_sh_q  <= {1'b0, tx_sh_q[8:1]};
      tx_bit_q <= tx_bit_q + 4'd1;
      tx_div_q <= BAUD_LAST;
    end
  end

  assign leds        = leds_q;
  assign ser_tx      = tx_q;
  assign flash_csb   = csb_q;
  assign flash_clk   = sck_q;
  assign flash_io0   = io0_q;
  assign flash_io2   = 1'b1;
  assign flash_io3   = 1'b1;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hx8k_demo.sv
module tb_hx8k_demo;
  localparam int BAUD = 16;
  localparam int MAXB = 256;
  localparam logic [2:0] ST_WAKE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ser_rx = 1'b1;
  logic flash_io1 = 1'b0;
  logic [7:0] leds;
  logic ser_tx, flash_csb, flash_clk, flash_io0, flash_io2, flash_io3;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  hx8k_demo #(.BAUD_DIV(BAUD), .FLASH_ADDR(24'h100000), .MAX_BYTES(MAXB)) dut (
    .clk(clk), .reset(reset), .leds(leds), .ser_rx(ser_rx), .ser_tx(ser_tx),
    .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
    .flash_io1(flash_io1), .flash_io2(flash_io2), .flash_io3(flash_io3),
    .dbg_state_o(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int passed = 0;
  logic [7:0]  exp_q[$];
  int          exp_bits_q[$];
  logic [31:0] exp_hdr_q[$];
  logic [7:0]  mem [0:511];
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  // Reference: one run streams bytes from offset 0 until a zero byte or MAXB bytes.
  task automatic push_run();
    int n;
    n = 0;
    while (n < MAXB && mem[n] != 8'h00) begin
      exp_q.push_back(mem[n]);
      n++;
    end
    exp_bits_q.push_back(8);
    exp_hdr_q.push_back(32'h0000_00AB);
    // Reads stop after the zero byte, or right after the MAXB-th byte.
    exp_bits_q.push_back(32 + 8 * ((n < MAXB) ? n + 1 : n));
    exp_hdr_q.push_back(32'h0310_0000);
  endtask

  task automatic flush();
    exp_q.delete();
    exp_bits_q.delete();
    exp_hdr_q.delete();
  endtask

  // ---------------- UART monitor ----------------
  int um_cnt, um_frames = 0, um_k, last_start;
  logic um_busy, um_prev, um_start;
  logic [7:0] um_byte;

  always @(negedge clk) begin
    if (reset) begin
      um_busy = 1'b0;
      um_prev = 1'b1;
      last_start = -1;
    end else if (!um_busy) begin
      if (um_prev && !ser_tx) begin
        um_busy = 1'b1;
        um_cnt = 0;
        if (last_start >= 0) chk("frame spacing >= 10 bits", 32'((cyc - last_start) >= 10 * BAUD), 32'd1);
        last_start = cyc;
      end
      um_prev = ser_tx;
    end else begin
      um_cnt++;
      if (um_cnt % BAUD == BAUD / 2) begin
        um_k = um_cnt / BAUD;
        if (um_k == 0) um_start = ser_tx;
        else if (um_k <= 8) um_byte[um_k-1] = ser_tx;
        else begin
          chk("start bit", 32'(um_start), 32'd0);
          chk("stop bit", 32'(ser_tx), 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected frame: got %0h expected none", um_byte);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("frame data", 32'(um_byte), 32'(e));
            chk("leds during frame", 32'(leds), 32'(e));
          end
          um_frames++;
          um_busy = 1'b0;
          um_prev = ser_tx;
        end
      end
    end
  end

  // ---------------- SPI monitor + flash model ----------------
  int sp_bits, sp_bad = 0, sp_n, sp_idx;
  logic [31:0] sp_hdr;
  logic sp_prev_sck, sp_prev_csb;
  logic [7:0] sp_b;

  always @(negedge clk) begin
    if (reset) begin
      sp_prev_sck = 1'b0;
      sp_prev_csb = 1'b1;
      flash_io1 = 1'b0;
    end else begin
      if (sp_prev_csb && !flash_csb) begin
        sp_bits = 0;
        sp_hdr = 32'h0;
      end
      if (!flash_csb) begin
        if (!sp_prev_sck && flash_clk) begin
          if (sp_bits < 32) sp_hdr = {sp_hdr[30:0], flash_io0};
          sp_bits++;
        end
        if (sp_prev_sck && !flash_clk && sp_bits >= 32 && sp_hdr[31:24] == 8'h03) begin
          sp_n = sp_bits - 32;
          sp_idx = int'(sp_hdr[23:0]) - 32'h100000 + sp_n / 8;
          sp_b = (sp_idx >= 0 && sp_idx < 512) ? mem[sp_idx] : 8'h00;
          flash_io1 = sp_b[7 - (sp_n % 8)];
        end
      end else if (flash_clk) begin
        sp_bad++;
      end
      if (flash_io2 !== 1'b1 || flash_io3 !== 1'b1) sp_bad++;
      if (!sp_prev_csb && flash_csb) begin
        if (exp_bits_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected burst: got %0d bits expected none", sp_bits);
        end else begin
          chk("burst bit count", 32'(sp_bits), 32'(exp_bits_q.pop_front()));
          chk("burst header", sp_hdr, exp_hdr_q.pop_front());
        end
        chk("spi pin rules", 32'(sp_bad), 32'd0);
      end
      sp_prev_sck = flash_clk;
      sp_prev_csb = flash_csb;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, 32'(dbg_state), 32'(s));
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk) #1 reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(posedge clk) #1 ser_rx = f[i];
      repeat (BAUD - 1) @(posedge clk);
    end
    @(posedge clk) #1 ser_rx = 1'b1;
  endtask

  task automatic end_of_run(input logic [7:0] last, input string tag);
    repeat (12 * BAUD) @(posedge clk);
    @(negedge clk);
    chk({tag, " frames outstanding"}, 32'(exp_q.size()), 32'd0);
    chk({tag, " bursts outstanding"}, 32'(exp_bits_q.size()), 32'd0);
    chk({tag, " leds final"}, 32'(leds), 32'(last));
    chk({tag, " csb high in DONE"}, 32'(flash_csb), 32'd1);
    chk({tag, " sck low in DONE"}, 32'(flash_clk), 32'd0);
    chk({tag, " ser_tx idle in DONE"}, 32'(ser_tx), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[0] = 8'h48;
    mem[1] = 8'h69;

    // Run 1: "Hi" then zero terminator
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset csb", 32'(flash_csb), 32'd1);
    chk("reset sck", 32'(flash_clk), 32'd0);
    chk("reset io0", 32'(flash_io0), 32'd0);
    chk("reset ser_tx", 32'(ser_tx), 32'd1);
    chk("reset leds", 32'(leds), 32'd0);
    chk("reset state", 32'(dbg_state), 32'(ST_WAKE));
    push_run();
    #1 reset = 1'b0;
    wait_state(ST_DONE, 3000, "run1 reaches DONE");
    end_of_run(8'h69, "run1");

`ifdef HX8K_DEMO_RX_EN
    // Receiver: good frame is shown and echoed, bad stop bit is dropped
    exp_q.push_back(8'h5A);
    uart_send(8'h5A, 1'b1);
    repeat (14 * BAUD) @(posedge clk);
    @(negedge clk);
    chk("rx leds", 32'(leds), 32'h5A);
    chk("rx echo consumed", 32'(exp_q.size()), 32'd0);
    base = um_frames;
    uart_send(8'h33, 1'b0);
    repeat (14 * BAUD) @(posedge clk);
    @(negedge clk);
    chk("bad stop leds kept", 32'(leds), 32'h5A);
    chk("bad stop no echo", 32'(um_frames), 32'(base));
`endif

    // Run 2: reset pulse in the middle of the second frame
    do_reset(3);
    @(negedge clk);
    flush();
    push_run();
    #1 reset = 1'b0;
    base = um_frames;
    n = 0;
    while (!(um_frames == base + 1 && um_busy && um_cnt >= 3 * BAUD) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("second frame in flight", 32'(um_frames == base + 1 && um_busy), 32'd1);
    @(posedge clk) #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort ser_tx", 32'(ser_tx), 32'd1);
    chk("abort csb", 32'(flash_csb), 32'd1);
    chk("abort sck", 32'(flash_clk), 32'd0);
    chk("abort leds", 32'(leds), 32'd0);
    chk("abort state", 32'(dbg_state), 32'(ST_WAKE));
    flush();
    push_run();
    #1 reset = 1'b0;
    wait_state(ST_DONE, 3000, "restart reaches DONE");
    end_of_run(8'h69, "restart");

    // Run 3: 300 non-zero bytes, capped at MAXB frames
    do_reset(3);
    for (int i = 0; i < 300; i++) mem[i] = 8'($urandom_range(1, 255));
    mem[300] = 8'h00;
    @(negedge clk);
    flush();
    push_run();
    #1 reset = 1'b0;
    base = um_frames;
    wait_state(ST_DONE, MAXB * (10 * BAUD + 40) + 500, "long run reaches DONE");
    end_of_run(mem[MAXB-1], "long");
    chk("long frame count", 32'(um_frames - base), 32'(MAXB));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
